// File: rtl/i2c_frame_sequencer.sv
// Sweeps the command frames of up to NUM_BOARDS arm boards through an i2c_master, in 3-byte chunks, retrying on NACK.
// Compile option SEQ_ANGLE_READ_EN appends a read of the elbow angle sensor to every sweep.
module i2c_frame_sequencer #(
  parameter int NUM_BOARDS  = 4,
  parameter int FRAME_BITS  = 88,
  parameter int MAX_RETRIES = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [NUM_BOARDS-1:0]            board_enable,
  input  logic [7*NUM_BOARDS-1:0]          board_device_id,
  input  logic [FRAME_BITS*NUM_BOARDS-1:0] command_frames,
  input  logic [6:0]                       angle_device_id,
  output logic                             i2c_ena,
  output logic                             i2c_rw,
  output logic [6:0]                       i2c_addr,
  output logic [31:0]                      i2c_data_wr,
  output logic [7:0]                       i2c_number_of_bytes,
  input  logic                             i2c_busy,
  input  logic                             i2c_ack_error,
  input  logic [7:0]                       i2c_byte_counter,
  input  logic [31:0]                      i2c_data_rd,
  output logic                             done,
  output logic [NUM_BOARDS-1:0]            error_flags,
  output logic [11:0]                      angle,
  output logic                             angle_valid,
  output logic [15:0]                      txn_count,
  output logic [15:0]                      err_count
);

  localparam int CHUNKS = (FRAME_BITS + 23) / 24;
  localparam int PADW   = CHUNKS * 24;
  localparam int BW     = $clog2(NUM_BOARDS + 1);
  localparam int IW     = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_ISSUE, S_WAIT, S_CHECK,
`ifdef SEQ_ANGLE_READ_EN
    S_ANGLE_ISSUE, S_ANGLE_WAIT,
`endif
    S_FINISH
  } state_t;

  state_t state_q, state_d;

  logic [BW-1:0]         board_q;
  logic [CW-1:0]         chunk_q;
  logic [7:0]            retries_q;
  logic [NUM_BOARDS-1:0] en_q;
  logic [6:0]            id_q    [NUM_BOARDS];
  logic [PADW-1:0]       frame_q [NUM_BOARDS];

  logic [IW-1:0] bsel;
  logic          sweep_end, board_on, last_chunk, retry_ok, xfer_done, drop_ena;
  logic [23:0]   chunk_data;
  logic          unused_ok;

  assign bsel       = board_q[IW-1:0];
  assign sweep_end  = (board_q == BW'(NUM_BOARDS));
  assign board_on   = !sweep_end && en_q[bsel];
  assign last_chunk = (chunk_q == CW'(CHUNKS - 1));
  assign retry_ok   = (retries_q < 8'(MAX_RETRIES));
  assign xfer_done  = !i2c_busy && !i2c_ena;
  assign drop_ena   = i2c_ena && (i2c_byte_counter >= i2c_number_of_bytes);
  assign chunk_data = 24'(frame_q[bsel] >> (24 * chunk_q));
  assign unused_ok  = ^{i2c_data_rd, angle_device_id};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_SELECT;
      S_SELECT: begin
        if (sweep_end) begin
`ifdef SEQ_ANGLE_READ_EN
          state_d = S_ANGLE_ISSUE;
`else
          state_d = S_FINISH;
`endif
        end else if (board_on) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT:   if (xfer_done) state_d = S_CHECK;
      S_CHECK:  state_d = S_SELECT;
`ifdef SEQ_ANGLE_READ_EN
      S_ANGLE_ISSUE: state_d = S_ANGLE_WAIT;
      S_ANGLE_WAIT:  if (xfer_done) state_d = S_FINISH;
`endif
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Inputs are captured once per sweep so callers may change them mid-sweep
  always_ff @(posedge clock) begin
    if (state_q == S_IDLE && start) begin
      en_q <= board_enable;
      for (int b = 0; b < NUM_BOARDS; b++) begin
        id_q[b]    <= board_device_id[7*b +: 7];
        frame_q[b] <= PADW'(command_frames[FRAME_BITS*b +: FRAME_BITS]);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      board_q             <= '0;
      chunk_q             <= '0;
      retries_q           <= '0;
      i2c_ena             <= 1'b0;
      i2c_rw              <= 1'b0;
      i2c_addr            <= '0;
      i2c_data_wr         <= '0;
      i2c_number_of_bytes <= '0;
      done                <= 1'b1;
      error_flags         <= '0;
      txn_count           <= '0;
      err_count           <= '0;
`ifdef SEQ_ANGLE_READ_EN
      angle               <= '0;
      angle_valid         <= 1'b0;
`endif
    end else begin
`ifdef SEQ_ANGLE_READ_EN
      angle_valid <= 1'b0;
`endif
      case (state_q)
        S_IDLE: if (start) begin
          done        <= 1'b0;
          error_flags <= '0;
          board_q     <= '0;
          chunk_q     <= '0;
          retries_q   <= '0;
        end
        S_SELECT: begin
          if (sweep_end) begin
`ifdef SEQ_ANGLE_READ_EN
            i2c_rw              <= 1'b1;
            i2c_addr            <= angle_device_id;
            i2c_data_wr         <= {8'h20, 24'h0};
            i2c_number_of_bytes <= 8'd3;
            i2c_ena             <= 1'b1;
`else
            done                <= 1'b1;
`endif
          end else if (board_on) begin
            i2c_rw              <= 1'b0;
            i2c_addr            <= id_q[bsel];
            i2c_data_wr         <= {8'(chunk_q) + 8'd1, chunk_data};
            i2c_number_of_bytes <= 8'd3;
            i2c_ena             <= 1'b1;
          end else begin
            board_q <= board_q + 1'b1;
          end
        end
        S_WAIT: if (drop_ena) i2c_ena <= 1'b0;
        S_CHECK: begin
          if (!i2c_ack_error) begin
            txn_count <= txn_count + 16'd1;
            retries_q <= '0;
            chunk_q   <= last_chunk ? '0 : chunk_q + 1'b1;
            if (last_chunk) board_q <= board_q + 1'b1;
          end else begin
            err_count <= err_count + 16'd1;
            if (retry_ok) begin
              retries_q <= retries_q + 8'd1;
            end else begin
              // give up on this board entirely and move on
              error_flags[bsel] <= 1'b1;
              retries_q         <= '0;
              chunk_q           <= '0;
              board_q           <= board_q + 1'b1;
            end
          end
        end
`ifdef SEQ_ANGLE_READ_EN
        S_ANGLE_WAIT: begin
          if (drop_ena) i2c_ena <= 1'b0;
          if (xfer_done) begin
            done <= 1'b1;
            if (!i2c_ack_error) begin
              angle       <= i2c_data_rd[27:16];
              angle_valid <= 1'b1;
            end else begin
              err_count <= err_count + 16'd1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifndef SEQ_ANGLE_READ_EN
  assign angle       = '0;
  assign angle_valid = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_frame_sequencer.sv
// Randomized bench for i2c_frame_sequencer: a bus-functional i2c_master plus a nested-loop sweep model.
module tb_i2c_frame_sequencer;
  localparam int NB = 4;
  localparam int FB = 88;
  localparam int MR = 2;
  localparam int CH = (FB + 23) / 24;

  logic clock = 1'b0;
  logic reset, start;
  logic [NB-1:0]    board_enable;
  logic [7*NB-1:0]  board_device_id;
  logic [FB*NB-1:0] command_frames;
  logic [6:0]       angle_device_id;
  logic             i2c_ena, i2c_rw;
  logic [6:0]       i2c_addr;
  logic [31:0]      i2c_data_wr;
  logic [7:0]       i2c_number_of_bytes;
  logic             i2c_busy, i2c_ack_error;
  logic [7:0]       i2c_byte_counter;
  logic [31:0]      i2c_data_rd;
  logic             done;
  logic [NB-1:0]    error_flags;
  logic [11:0]      angle;
  logic             angle_valid;
  logic [15:0]      txn_count, err_count;

  i2c_frame_sequencer #(.NUM_BOARDS(NB), .FRAME_BITS(FB), .MAX_RETRIES(MR)) dut (
    .clock(clock), .reset(reset), .start(start), .board_enable(board_enable),
    .board_device_id(board_device_id), .command_frames(command_frames),
    .angle_device_id(angle_device_id), .i2c_ena(i2c_ena), .i2c_rw(i2c_rw),
    .i2c_addr(i2c_addr), .i2c_data_wr(i2c_data_wr), .i2c_number_of_bytes(i2c_number_of_bytes),
    .i2c_busy(i2c_busy), .i2c_ack_error(i2c_ack_error), .i2c_byte_counter(i2c_byte_counter),
    .i2c_data_rd(i2c_data_rd), .done(done), .error_flags(error_flags), .angle(angle),
    .angle_valid(angle_valid), .txn_count(txn_count), .err_count(err_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [6:0]  addr;
    logic        rw;
    logic [31:0] data;
    logic [7:0]  nb;
  } txn_t;

  // sweep plan shared by the slave model and the reference model
  logic [NB-1:0] p_en;
  logic [6:0]    p_id [NB];
  logic [FB-1:0] p_frame [NB];
  logic [6:0]    p_angle_id;
  bit            p_nack [NB][CH][MR+1];
  bit            p_angle_nack;
  logic [31:0]   p_rd;
  int            attempts [NB][CH];

  txn_t obs_q[$], exp_q[$];
  logic [NB-1:0] exp_flags;
  logic [15:0]   exp_txn, exp_err;
  logic [11:0]   exp_angle;
  int            exp_pulses, valid_pulses;
  bit            unstable;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: walk boards and chunks in order, retrying each chunk per the NACK plan.
  task automatic build_expected();
    logic [95:0] pad;
    exp_q.delete();
    exp_flags  = '0;
    exp_pulses = 0;
    for (int b = 0; b < NB; b++) begin
      if (!p_en[b]) continue;
      pad = 96'(p_frame[b]);
      for (int k = 0; k < CH; k++) begin
        int a;
        bit failed;
        a = 0;
        failed = 0;
        while (1) begin
          exp_q.push_back('{addr: p_id[b], rw: 1'b0,
                            data: {8'(k + 1), 24'(pad >> (24 * k))}, nb: 8'd3});
          if (p_nack[b][k][a]) begin
            exp_err++;
            if (a < MR) a++;
            else begin failed = 1; break; end
          end else begin
            exp_txn++;
            break;
          end
        end
        if (failed) begin exp_flags[b] = 1'b1; break; end
      end
    end
`ifdef SEQ_ANGLE_READ_EN
    exp_q.push_back('{addr: p_angle_id, rw: 1'b1, data: {8'h20, 24'h0}, nb: 8'd3});
    if (p_angle_nack) exp_err++;
    else begin exp_angle = p_rd[27:16]; exp_pulses = 1; end
`endif
  endtask

  // Bus-functional i2c_master: one byte per cycle with random stalls
  initial begin
    txn_t cur;
    bit busy_m, nack_m;
    int m_b, m_k;
    i2c_busy = 0; i2c_ack_error = 0; i2c_byte_counter = 0; i2c_data_rd = 0;
    busy_m = 0; nack_m = 0; cur = '0;
    forever begin
      @(posedge clock); #1;
      if (angle_valid) valid_pulses++;
      if (reset) begin
        busy_m = 0; i2c_busy = 0; i2c_byte_counter = 0; i2c_ack_error = 0;
      end else if (!busy_m) begin
        if (i2c_ena) begin
          cur = '{addr: i2c_addr, rw: i2c_rw, data: i2c_data_wr, nb: i2c_number_of_bytes};
          obs_q.push_back(cur);
          busy_m = 1; i2c_busy = 1; i2c_byte_counter = 0; i2c_ack_error = 0;
          nack_m = 0;
          if (cur.rw) nack_m = p_angle_nack;
          else begin
            m_k = int'(cur.data[31:24]) - 1;
            m_b = -1;
            for (int b = 0; b < NB; b++) if (p_id[b] == cur.addr) m_b = b;
            if (m_b >= 0 && m_k >= 0 && m_k < CH) begin
              if (attempts[m_b][m_k] <= MR) nack_m = p_nack[m_b][m_k][attempts[m_b][m_k]];
              attempts[m_b][m_k]++;
            end
          end
        end
      end else begin
        if (i2c_ena && {i2c_addr, i2c_rw, i2c_data_wr, i2c_number_of_bytes} != cur) unstable = 1;
        if (i2c_byte_counter < cur.nb) begin
          if ($urandom_range(0, 3) != 0) i2c_byte_counter++;
        end else if (!i2c_ena) begin
          busy_m = 0; i2c_busy = 0; i2c_ack_error = nack_m;
          i2c_data_rd = cur.rw ? p_rd : $urandom;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic new_plan(input logic [NB-1:0] en, input int nack_pct);
    p_en = en;
    for (int b = 0; b < NB; b++) begin
      p_id[b]    = 7'(($urandom_range(0, 31) << 2) | b);
      p_frame[b] = FB'({$urandom, $urandom, $urandom});
      for (int k = 0; k < CH; k++)
        for (int a = 0; a <= MR; a++) p_nack[b][k][a] = ($urandom_range(0, 99) < nack_pct);
    end
    p_angle_id   = 7'($urandom);
    p_angle_nack = ($urandom_range(0, 99) < nack_pct);
    p_rd         = $urandom;
  endtask

  task automatic run_sweep(input bit mid_start, input int reset_at);
    int  cyc;
    bit  ena_seen;
    for (int b = 0; b < NB; b++) begin
      board_enable[b]                 = p_en[b];
      board_device_id[7*b +: 7]       = p_id[b];
      command_frames[FB*b +: FB]      = p_frame[b];
      for (int k = 0; k < CH; k++) attempts[b][k] = 0;
    end
    angle_device_id = p_angle_id;
    build_expected();
    obs_q.delete();
    valid_pulses = 0;
    unstable = 0;
    tick(); start = 1;
    tick(); start = 0;
    check("done_low", done, 1'b0);
    board_enable    = NB'($urandom);
    board_device_id = {$urandom, $urandom};
    command_frames  = {12{$urandom}};
    angle_device_id = 7'($urandom);
    cyc = 0;
    while (!done && cyc < 5000) begin
      tick(); cyc++;
      start = (mid_start && cyc == 40);
      if (reset_at >= 0 && obs_q.size() == reset_at + 1 && i2c_ena) begin
        check("ena_before_reset", i2c_ena, 1'b1);
        reset = 1; #1;
        check("rst_ena", i2c_ena, 1'b0);
        check("rst_done", done, 1'b1);
        check("rst_txn", txn_count, 16'd0);
        check("rst_err", err_count, 16'd0);
        check("rst_flags", error_flags, '0);
        tick(); tick(); reset = 0;
        ena_seen = 0;
        repeat (6) begin tick(); if (i2c_ena) ena_seen = 1; end
        check("no_ena_after_reset", ena_seen, 1'b0);
        exp_txn = 0; exp_err = 0; exp_angle = 0;
        return;
      end
    end
    start = 0;
    check("sweep_done", done, 1'b1);
    check("txn_total", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) check("txn", obs_q[i], exp_q[i]);
    check("error_flags", error_flags, exp_flags);
    check("txn_count", txn_count, exp_txn);
    check("err_count", err_count, exp_err);
    check("angle", angle, exp_angle);
    check("angle_valid_pulses", valid_pulses, exp_pulses);
    check("req_stable", unstable, 1'b0);
    tick(); tick();
  endtask

  initial begin
    logic [15:0] t0, e0;
    reset = 1; start = 0;
    board_enable = '0; board_device_id = '0; command_frames = '0; angle_device_id = '0;
    exp_txn = 0; exp_err = 0; exp_angle = 0;
    repeat (3) tick();
    check("reset_done", done, 1'b1);
    check("reset_ena", i2c_ena, 1'b0);
    check("reset_rw", i2c_rw, 1'b0);
    check("reset_data", i2c_data_wr, 32'h0);
    check("reset_nbytes", i2c_number_of_bytes, 8'h0);
    check("reset_flags", error_flags, '0);
    check("reset_angle", angle, 12'h0);
    check("reset_valid", angle_valid, 1'b0);
    check("reset_txn", txn_count, 16'h0);
    check("reset_err", err_count, 16'h0);
    tick(); reset = 0; tick();

    // all boards, clean acks, known frame on board 0
    new_plan(4'hF, 0);
    p_frame[0] = 88'h1122_3344_5566_7788_99AA_BB;
    run_sweep(0, -1);
    check("b0_chunk3_data", (obs_q.size() > 3) ? obs_q[3].data : 32'h0, 32'h0400_1122);
    check("txn_count_16", txn_count, 16'd16);

    // board 2 NACKs every attempt
    new_plan(4'hF, 0);
    for (int k = 0; k < CH; k++) for (int a = 0; a <= MR; a++) p_nack[2][k][a] = 1;
    e0 = err_count;
    run_sweep(0, -1);
    check("flags_board2", error_flags, 4'b0100);
    check("err_delta_3", err_count - e0, 16'd3);

    // single NACK then ACK on board 1 chunk 1
    new_plan(4'hF, 0);
    p_nack[1][1][0] = 1;
    t0 = txn_count;
    run_sweep(0, -1);
    check("single_retry_flags", error_flags, 4'b0000);
    check("single_retry_txn", txn_count - t0, 16'd16);

    // no boards enabled
    new_plan(4'h0, 0);
    p_rd = 32'h0ABC_0000;
    run_sweep(0, -1);
`ifdef SEQ_ANGLE_READ_EN
    check("angle_abc", angle, 12'hABC);
    check("one_read_only", obs_q.size(), 1);
`else
    check("angle_zero", angle, 12'h0);
    check("no_requests", obs_q.size(), 0);
`endif

    // start pulsed mid-sweep is ignored
    new_plan(4'hF, 0);
    t0 = txn_count;
    run_sweep(1, -1);
    check("mid_start_txn", txn_count - t0, 16'd16);

    // reset during the sixth write, then a fresh sweep
    new_plan(4'hF, 0);
    run_sweep(0, 5);
    new_plan(4'hF, 0);
    run_sweep(0, -1);
    check("restart_first", (obs_q.size() > 0) ? obs_q[0].data[31:24] : 8'h0, 8'h01);
    check("restart_addr", (obs_q.size() > 0) ? obs_q[0].addr : 7'h0, p_id[0]);

    // randomized sweeps
    for (int r = 0; r < 8; r++) begin
      new_plan(NB'($urandom), 20);
      run_sweep(0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
